// File: rtl/gcd_pkg.sv
// Shared FSM state encoding and default sizing for the gcd engine scheduler.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD_A,
        LOAD_B,
        WAIT,
        RESP
    } state_t;

    localparam int SIZE_DEF = 8;
    localparam int NREQ_DEF = 4;
    localparam int TMO_DEF  = 255;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module gcd_rr_arbiter
    import gcd_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
                found     = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one serial-load gcd engine among NREQ requesters with round-robin arbitration.
// Optional WAIT timeout enabled by defining GCD_SCHED_TIMEOUT_EN.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int SIZE = SIZE_DEF,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = 2,
    parameter int TMO  = TMO_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [SIZE-1:0]      rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err,
    output logic                 gcd_start,
    output logic                 gcd_reset,
    output logic [SIZE-1:0]      gcd_data_in,
    input  logic [SIZE-1:0]      gcd_data_out,
    input  logic                 gcd_done
);

    if (NREQ < 2 || NREQ > 8 || IDW < $clog2(NREQ) || TMO < 1) begin : g_bad_cfg
        $error("gcd_scheduler: unsupported NREQ/IDW/TMO combination");
    end

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [SIZE-1:0] sel_a, sel_b;
    logic [SIZE-1:0] op_a, op_b;
    logic            done_q;
    logic            done_edge;
    logic            tmo_hit;
    logic            bypass;

    gcd_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign done_edge = gcd_done & ~done_q;
    assign bypass    = (sel_a == '0) || (sel_b == '0);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = sel_a | req_a[i*SIZE +: SIZE];
                sel_b = sel_b | req_b[i*SIZE +: SIZE];
            end
        end
    end

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (state == WAIT) && !done_edge && (tmo_cnt == CNT_W'(TMO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        gcd_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant;
                    state_nxt = bypass ? RESP : START;
                end
            end
            START: begin
                gcd_start = 1'b1;
                state_nxt = LOAD_A;
            end
            LOAD_A: state_nxt = LOAD_B;
            LOAD_B: state_nxt = WAIT;
            WAIT: begin
                if (done_edge || tmo_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rsp_data    <= '0;
            rsp_id      <= '0;
            rsp_err     <= 1'b0;
            gcd_data_in <= '0;
            gcd_reset   <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q    <= gcd_done;
            gcd_reset <= tmo_hit;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        rsp_id  <= grant_idx;
                        rsp_err <= 1'b0;
                        if (sel_a == '0) begin
                            rsp_data <= sel_b;
                        end else if (sel_b == '0) begin
                            rsp_data <= sel_a;
                        end
                    end
                end
                // Loaded one cycle early so the bus shows A during LOAD_A and B during LOAD_B.
                START:  gcd_data_in <= op_a;
                LOAD_A: gcd_data_in <= op_b;
                WAIT: begin
                    if (done_edge) begin
                        rsp_data <= gcd_data_out;
                    end else if (tmo_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler; the bench itself plays the gcd engine.
module tb_gcd_scheduler;

    localparam int SIZE = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SIZE-1:0] req_a = '0;
    logic [NREQ*SIZE-1:0] req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [SIZE-1:0]      rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_err;
    logic                 gcd_start;
    logic                 gcd_reset;
    logic [SIZE-1:0]      gcd_data_in;
    logic [SIZE-1:0]      gcd_data_out = '0;
    logic                 gcd_done = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_scheduler #(
        .SIZE (SIZE),
        .NREQ (NREQ),
        .IDW  (IDW),
        .TMO  (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_err      (rsp_err),
        .gcd_start    (gcd_start),
        .gcd_reset    (gcd_reset),
        .gcd_data_in  (gcd_data_in),
        .gcd_data_out (gcd_data_out),
        .gcd_done     (gcd_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
        req_valid[id]        = 1'b1;
        req_a[id*SIZE +: SIZE] = a;
        req_b[id*SIZE +: SIZE] = b;
    endtask

    // Entered at the negedge just before the accepting posedge; leaves at the
    // negedge where the response is first visible.
    task automatic run_job(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] res, input int id);
        @(negedge clk);
        req_valid[id] = 1'b0;
        chk("job_start_pulse", gcd_start, 1);
        chk("job_ready_low", req_ready, 0);
        @(negedge clk);
        chk("job_start_once", gcd_start, 0);
        chk("job_load_a", gcd_data_in, a);
        @(negedge clk);
        chk("job_load_b", gcd_data_in, b);
        @(negedge clk);
        chk("job_wait_stale_done", rsp_valid, 0);
        gcd_done = 1'b0;
        @(negedge clk);
        chk("job_wait_no_done", rsp_valid, 0);
        gcd_data_out = res;
        gcd_done     = 1'b1;
        @(negedge clk);
        chk("job_rsp_valid", rsp_valid, 1);
        chk("job_rsp_data", rsp_data, res);
        chk("job_rsp_id", rsp_id, id);
        chk("job_rsp_err", rsp_err, 0);
    endtask

    task automatic take_resp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_start", gcd_start, 0);
        chk("rst_data_in", gcd_data_in, 0);
        chk("rst_gcd_reset", gcd_reset, 1);
        reset = 1'b1;
        #1 chk("rst_release_hold", gcd_reset, 1);
        @(negedge clk);
        chk("rst_release_drop", gcd_reset, 0);

        // Simultaneous requests 0 and 2 with pointer at 0
        set_req(0, 8'd12, 8'd8);
        set_req(2, 8'd35, 8'd14);
        #1 chk("rr_grant0", req_ready, 4'b0001);
        run_job(8'd12, 8'd8, 8'd4, 0);
        take_resp();
        chk("rr_grant2", req_ready, 4'b0100);
        run_job(8'd35, 8'd14, 8'd7, 2);
        take_resp();

        // Pointer now 3: requester 3 wins over 0; zero bypass
        set_req(0, 8'd5, 8'd10);
        set_req(3, 8'd0, 8'd45);
        #1 chk("ptr3_grant", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        chk("byp_valid", rsp_valid, 1);
        chk("byp_data", rsp_data, 45);
        chk("byp_id", rsp_id, 3);
        chk("byp_no_start", gcd_start, 0);
        take_resp();
        chk("byp_no_start_after", gcd_start, 0);

        // Requester 1: 48, 18
        set_req(1, 8'd48, 8'd18);
        #1 chk("t1_grant", req_ready, 4'b0010);
        run_job(8'd48, 8'd18, 8'd6, 1);
        take_resp();

        // Back-pressure on (9,6) with a pending request from 0
        set_req(2, 8'd9, 8'd6);
        #1 chk("bp_grant", req_ready, 4'b0100);
        run_job(8'd9, 8'd6, 8'd3, 2);
        set_req(0, 8'd21, 8'd14);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_data", rsp_data, 3);
            chk("bp_hold_id", rsp_id, 2);
            chk("bp_pending_blocked", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_handshake_blocked", req_ready, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_rsp_drop", rsp_valid, 0);
        chk("bp_pending_accept", req_ready, 4'b0001);

        // Reset during WAIT
        @(negedge clk);
        req_valid = '0;
        chk("mid_start", gcd_start, 1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_load_b", gcd_data_in, 14);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_id", rsp_id, 0);
        chk("mid_rst_err", rsp_err, 0);
        chk("mid_rst_start", gcd_start, 0);
        chk("mid_rst_data_in", gcd_data_in, 0);
        chk("mid_rst_gcd_reset", gcd_reset, 1);
        chk("mid_rst_ready", req_ready, 0);
        @(negedge clk);
        chk("mid_rst_held", gcd_reset, 1);
        reset = 1'b1;
        #1 chk("mid_release_hold", gcd_reset, 1);
        @(negedge clk);
        chk("mid_release_drop", gcd_reset, 0);
        chk("mid_release_idle", rsp_valid, 0);
        set_req(0, 8'd100, 8'd75);
        #1 chk("post_rst_grant", req_ready, 4'b0001);
        run_job(8'd100, 8'd75, 8'd25, 0);
        take_resp();

`ifdef GCD_SCHED_TIMEOUT_EN
        // Engine never completes: timeout after 20 WAIT cycles
        gcd_done = 1'b0;
        set_req(1, 8'd15, 8'd10);
        #1 chk("tmo_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        chk("tmo_start", gcd_start, 1);
        @(negedge clk);
        @(negedge clk);
        chk("tmo_load_b", gcd_data_in, 10);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("tmo_waiting", rsp_valid, 0);
            chk("tmo_no_reset", gcd_reset, 0);
        end
        @(negedge clk);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_data", rsp_data, 0);
        chk("tmo_rsp_id", rsp_id, 1);
        chk("tmo_gcd_reset", gcd_reset, 1);
        @(negedge clk);
        chk("tmo_reset_pulse_end", gcd_reset, 0);
        chk("tmo_rsp_held", rsp_valid, 1);
        take_resp();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
